// File: rtl/updown_monitor_pkg.sv
// Shared definitions for the up/down counter path: monitor FSM states and the
// active-low 7-segment glyph table used by both the counter encoder and the monitor.
package updown_monitor_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Bit order is {g,f,e,d,c,b,a}; a lit segment is driven low.
  function automatic logic [6:0] seg_glyph(input logic [3:0] v);
    logic [6:0] lit;
    case (v)
      4'h0:    lit = 7'h3F;
      4'h1:    lit = 7'h06;
      4'h2:    lit = 7'h5B;
      4'h3:    lit = 7'h4F;
      4'h4:    lit = 7'h66;
      4'h5:    lit = 7'h6D;
      4'h6:    lit = 7'h7D;
      4'h7:    lit = 7'h07;
      4'h8:    lit = 7'h7F;
      4'h9:    lit = 7'h6F;
      4'hA:    lit = 7'h77;
      4'hB:    lit = 7'h7C;
      4'hC:    lit = 7'h39;
      4'hD:    lit = 7'h5E;
      4'hE:    lit = 7'h79;
      default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/updown_monitor_if.sv
// Counter output bus as seen by the monitor: counter-side samples in, monitor reports out.
interface updown_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
);

  logic [WIDTH-1:0] q_in;
  logic             x_in;
  logic [6:0]       seg_in;
  logic             locked;
  logic             dir_up;
  logic             wrap_up;
  logic             wrap_dn;
  logic             step_err;
  logic             x_err;
  logic             seg_err;
  logic [ERRW-1:0]  err_cnt;

  modport master (
    output q_in, x_in, seg_in,
    input  locked, dir_up, wrap_up, wrap_dn, step_err, x_err, seg_err, err_cnt
  );

  modport slave (
    input  q_in, x_in, seg_in,
    output locked, dir_up, wrap_up, wrap_dn, step_err, x_err, seg_err, err_cnt
  );

endinterface

// File: rtl/updown_monitor_seg7_decode.sv
// Combinational 7-segment decoder: maps an active-low pattern back to its hex digit
// and flags patterns that match no glyph.
module seg7_decode
  import updown_monitor_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       known
);

  always_comb begin
    value = '0;
    known = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == seg_glyph(4'(i))) begin
        value = 4'(i);
        known = 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_monitor.sv
// On-chip checker for the up/down counter bus: tracks direction and wraps, and
// reports step, terminal-flag and segment errors as registered one-cycle pulses.
module updown_monitor
  import updown_monitor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAXV  = 15,
  parameter int ERRW  = 8
) (
  input  logic           clk,
  input  logic           clr,
  updown_monitor_if.slave bus
);

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAXV);
  localparam logic [WIDTH:0]   DMAX = (WIDTH+1)'(MAXV);
  localparam logic [WIDTH:0]   MODV = (WIDTH+1)'(MAXV + 1);
  localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic             dir_q, dir_nxt;
  logic             wrap_up_q, wrap_dn_q, step_err_q, x_err_q, seg_err_q;
  logic [ERRW-1:0]  err_q, cnt_nxt;

  logic [WIDTH:0]   qx, px, delta;
  logic             step_up, step_dn, dir_now, x_exp;
  logic             step_ev, x_ev, seg_ev, wrap_up_ev, wrap_dn_ev;
  logic [3:0]       seg_val;
  logic             seg_known;
  logic [1:0]       n_err;
  logic [ERRW+1:0]  cnt_sum;

  seg7_decode u_dec (
    .seg   (bus.seg_in),
    .value (seg_val),
    .known (seg_known)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Step/flag checks are evaluated every cycle but only reported once a reference sample exists.
  always_comb begin
    state_nxt  = state;
    step_ev    = 1'b0;
    x_ev       = 1'b0;
    wrap_up_ev = 1'b0;
    wrap_dn_ev = 1'b0;
    dir_nxt    = dir_q;

    qx      = {1'b0, bus.q_in};
    px      = {1'b0, prev};
    delta   = (qx >= px) ? (qx - px) : (qx + MODV - px);
    step_up = (delta == ONE);
    step_dn = (delta == DMAX);
    dir_now = step_up ? 1'b1 : (step_dn ? 1'b0 : dir_q);
    x_exp   = ((bus.q_in == QMAX) & dir_now) | ((bus.q_in == '0) & ~dir_now);
    seg_ev  = ~seg_known | (32'(seg_val) != 32'(bus.q_in)) | (qx > DMAX);

    case (state)
      ST_INIT: state_nxt = ST_TRACK;
      ST_TRACK: begin
        state_nxt  = ST_TRACK;
        step_ev    = ~(step_up | step_dn);
        x_ev       = (bus.x_in != x_exp);
        wrap_up_ev = (prev == QMAX) && (bus.q_in == '0);
        wrap_dn_ev = (prev == '0) && (bus.q_in == QMAX);
        dir_nxt    = dir_now;
      end
      default: state_nxt = ST_INIT;
    endcase

    n_err   = {1'b0, step_ev} + {1'b0, x_ev} + {1'b0, seg_ev};
    cnt_sum = {2'b00, err_q} + (ERRW+2)'(n_err);
    cnt_nxt = (cnt_sum > {2'b00, {ERRW{1'b1}}}) ? '1 : cnt_sum[ERRW-1:0];
  end

  // prev follows q_in unconditionally so a jump resynchronises the tracker.
  always_ff @(posedge clk) begin
    if (clr) begin
      prev       <= '0;
      dir_q      <= 1'b1;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      step_err_q <= 1'b0;
      x_err_q    <= 1'b0;
      seg_err_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      prev       <= bus.q_in;
      dir_q      <= dir_nxt;
      wrap_up_q  <= wrap_up_ev;
      wrap_dn_q  <= wrap_dn_ev;
      step_err_q <= step_ev;
      x_err_q    <= x_ev;
      seg_err_q  <= seg_ev;
      err_q      <= cnt_nxt;
    end
  end

  assign bus.locked   = (state == ST_TRACK);
  assign bus.dir_up   = dir_q;
  assign bus.wrap_up  = wrap_up_q;
  assign bus.wrap_dn  = wrap_dn_q;
  assign bus.step_err = step_err_q;
  assign bus.x_err    = x_err_q;
  assign bus.seg_err  = seg_err_q;
  assign bus.err_cnt  = err_q;

endmodule
